// File: rtl/sort_stream_adapter_pkg.sv
// Shared types for the sorter stream adapter: FSM state encoding and
// the width of the per-frame word counter.
package sort_stream_adapter_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // The counter must be able to hold MAX_LENGTH itself, not just MAX_LENGTH-1.
    function automatic int count_width(input int max_length);
        return $clog2(max_length + 1);
    endfunction

endpackage

// File: rtl/sort_stream_adapter.sv
// Valid/ready front and back end for the parallel sorter: packs a word frame
// into the sorter bus, strobes the sorter once, then streams the result out.
module sort_stream_adapter
    import sort_stream_adapter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LENGTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_last,
    output logic [MAX_LENGTH*DATA_WIDTH-1:0] sort_in,
    output logic                             sort_enable,
    input  logic [MAX_LENGTH*DATA_WIDTH-1:0] sort_out,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             m_last,
    output logic                             busy
);

    // Handshake rule for both streams: a word moves on a rising edge where
    // valid && ready; the source holds data/last stable while valid && !ready.

    localparam int CW = count_width(MAX_LENGTH);

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_LOAD;
            count       <= '0;
            idx         <= '0;
            sort_in     <= '0;
            s_ready     <= 1'b1;
            sort_enable <= 1'b0;
            m_valid     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (s_valid && s_ready) begin
                        for (int k = 0; k < MAX_LENGTH; k++) begin
                            if (count == CW'(k)) begin
                                sort_in[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                            end
                        end
                        count <= count + CW'(1);
                        // A full frame closes on its own; s_last on that word is redundant.
                        if (s_last || count == CW'(MAX_LENGTH - 1)) begin
                            state       <= ST_SORT;
                            s_ready     <= 1'b0;
                            sort_enable <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                end
                ST_SORT: begin
                    state       <= ST_DRAIN;
                    sort_enable <= 1'b0;
                    m_valid     <= 1'b1;
                end
                ST_DRAIN: begin
                    if (m_valid && m_ready) begin
                        if (idx == count - CW'(1)) begin
                            // Clearing sort_in keeps unused slots at zero for the next frame.
                            state   <= ST_LOAD;
                            idx     <= '0;
                            count   <= '0;
                            sort_in <= '0;
                            m_valid <= 1'b0;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end
                end
                default: begin
                    state       <= ST_LOAD;
                    idx         <= '0;
                    count       <= '0;
                    sort_in     <= '0;
                    s_ready     <= 1'b1;
                    sort_enable <= 1'b0;
                    m_valid     <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // sort_out only matters while draining; elsewhere the outputs sit at zero.
    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        if (m_valid) begin
            for (int k = 0; k < MAX_LENGTH; k++) begin
                if (idx == CW'(k)) begin
                    m_data = sort_out[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            m_last = (idx == count - CW'(1));
        end
    end

endmodule
